// File: rtl/noc_pkg.sv
// noc_pkg
// Shared definitions for the network-interface injection path:
//   - bit positions of the dx / dy / tag fields inside a 64-bit flit
//   - make_flit() packs a tile request into a flit
//   - ni_state_t is the congestion tracker state encoding
//   - CNT_SAT is the saturation value of the 32-bit statistics counters
package noc_pkg;

    localparam int DX_MSB  = 63;
    localparam int DX_LSB  = 56;
    localparam int DY_MSB  = 55;
    localparam int DY_LSB  = 48;
    localparam int TAG_MSB = 15;
    localparam int TAG_LSB = 0;

    localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLOWING   = 2'd1,
        STALLED   = 2'd2,
        CONGESTED = 2'd3
    } ni_state_t;

    // Every field not carrying dx, dy or tag is zero (including the 2-bit
    // type field at [47:46], which marks a plain data flit).
    function automatic logic [63:0] make_flit(input logic [7:0]  dx,
                                              input logic [7:0]  dy,
                                              input logic [15:0] tag);
        logic [63:0] f;
        f                  = '0;
        f[DX_MSB:DX_LSB]   = dx;
        f[DY_MSB:DY_LSB]   = dy;
        f[TAG_MSB:TAG_LSB] = tag;
        return f;
    endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// noc_ni_fifo
// Synchronous FIFO with an occupancy count, asynchronous active-low reset.
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   push_i, din_i       write request and data (ignored when full)
//   pop_i               read request (ignored when empty)
//   dout_o              head entry; all zeros while empty
//   count_o             number of entries currently stored
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module noc_ni_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (count_q < CNT_W'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: the output is gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/noc_local_injector.sv
// noc_local_injector
// Injection stage between a tile and the router's local input port. Packs
// tile requests into flits, queues them in noc_ni_fifo and offers them to
// the router with valid/ready. A small FSM tracks back-pressure and raises
// `congested` after STALL_LIMIT consecutive stalled cycles.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   req_valid/req_ready            tile request handshake
//   req_dx, req_dy, req_tag        request fields
//   flit_out/valid_out/ready_in    router local-port handshake
//   occupancy                      FIFO entries in use
//   congested                      registered congestion flag
//   inject_count, stall_count,
//   peak_occupancy                 statistics (zero unless enabled)
// Build option: define NOC_INJECTOR_STATS_EN to implement the statistics
// counters; otherwise they are tied to zero.
module noc_local_injector
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH  = 64,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_dx,
    input  logic [7:0]            req_dy,
    input  logic [15:0]           req_tag,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [4:0]            occupancy,
    output logic                  congested,
    output logic [31:0]           inject_count,
    output logic [31:0]           stall_count,
    output logic [4:0]            peak_occupancy
);

    logic [FLIT_WIDTH-1:0] packed_flit;
    logic                  push;
    logic                  pop;
    logic                  stall;
    logic [4:0]            occ_next;
    logic [7:0]            stall_run_d;
    ni_state_t             state_q;
    logic [7:0]            stall_run_q;
    logic                  congested_q;

    assign packed_flit = make_flit(req_dx, req_dy, req_tag);

    // Acceptance depends only on the registered count, never on ready_in.
    assign req_ready = (occupancy < 5'(DEPTH));
    assign valid_out = (occupancy != 5'd0);
    assign push      = req_valid && req_ready;
    assign pop       = valid_out && ready_in;
    assign stall     = valid_out && !ready_in;
    assign occ_next  = occupancy + {4'd0, push} - {4'd0, pop};

    noc_ni_fifo #(
        .WIDTH (FLIT_WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (5)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .din_i   (packed_flit),
        .pop_i   (pop),
        .dout_o  (flit_out),
        .count_o (occupancy)
    );

    assign stall_run_d = (stall_run_q == 8'hFF) ? 8'hFF : stall_run_q + 8'd1;

    // Emptiness wins over everything; a pop always releases the stall run.
    // Since valid_out is high whenever the FIFO is non-empty, every
    // non-empty cycle either pops or stalls, so stall runs are consecutive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stall_run_q <= 8'd0;
            congested_q <= 1'b0;
        end else if (occ_next == 5'd0) begin
            state_q     <= IDLE;
            stall_run_q <= 8'd0;
            congested_q <= 1'b0;
        end else if (pop) begin
            state_q     <= FLOWING;
            stall_run_q <= 8'd0;
            congested_q <= 1'b0;
        end else if (stall) begin
            stall_run_q <= stall_run_d;
            if (stall_run_d >= 8'(STALL_LIMIT)) begin
                state_q     <= CONGESTED;
                congested_q <= 1'b1;
            end else begin
                state_q     <= STALLED;
                congested_q <= 1'b0;
            end
        end else if (state_q == IDLE) begin
            state_q <= FLOWING;
        end
    end

    assign congested = congested_q;

`ifdef NOC_INJECTOR_STATS_EN
    logic [31:0] inject_q;
    logic [31:0] stall_cnt_q;
    logic [4:0]  peak_q;

    // Peak follows the registered occupancy, so it lags it by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inject_q    <= 32'd0;
            stall_cnt_q <= 32'd0;
            peak_q      <= 5'd0;
        end else begin
            if (pop && inject_q != CNT_SAT)      inject_q    <= inject_q + 32'd1;
            if (stall && stall_cnt_q != CNT_SAT) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (occupancy > peak_q)              peak_q      <= occupancy;
        end
    end

    assign inject_count   = inject_q;
    assign stall_count    = stall_cnt_q;
    assign peak_occupancy = peak_q;
`else
    assign inject_count   = 32'd0;
    assign stall_count    = 32'd0;
    assign peak_occupancy = 5'd0;
`endif

endmodule

// File: tb/tb_noc_local_injector.sv
// tb_noc_local_injector
// Self-checking bench for noc_local_injector. A queue-based model tracks the
// expected FIFO contents, stall run and statistics; a negedge process
// compares every DUT output against it, and directed scenarios add literal
// expectations for key moments.
module tb_noc_local_injector;

    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 8;
`ifdef NOC_INJECTOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_dx;
    logic [7:0]  req_dy;
    logic [15:0] req_tag;
    logic [63:0] flit_out;
    logic        valid_out;
    logic        ready_in;
    logic [4:0]  occupancy;
    logic        congested;
    logic [31:0] inject_count;
    logic [31:0] stall_count;
    logic [4:0]  peak_occupancy;

    int vectors = 0;
    int errors  = 0;

    noc_local_injector #(
        .FLIT_WIDTH  (64),
        .DEPTH       (DEPTH),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dx         (req_dx),
        .req_dy         (req_dy),
        .req_tag        (req_tag),
        .flit_out       (flit_out),
        .valid_out      (valid_out),
        .ready_in       (ready_in),
        .occupancy      (occupancy),
        .congested      (congested),
        .inject_count   (inject_count),
        .stall_count    (stall_count),
        .peak_occupancy (peak_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mq [$];
    int          mRun  = 0;
    bit          mCong = 1'b0;
    int unsigned mInj  = 0;
    int unsigned mStl  = 0;
    int          mPeak = 0;

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] dx, input logic [7:0] dy,
                                 input logic [15:0] tag, input bit rdy);
        req_valid = v;
        req_dx    = dx;
        req_dy    = dy;
        req_tag   = tag;
        ready_in  = rdy;
        @(posedge clk);
        #1;
    endtask

    // Holds reset for one edge and releases it away from the clock edge;
    // outputs must already be at reset values right after assertion.
    task automatic resetDut();
        #2;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        #1;
        checkOutput("rst_valid_out", valid_out, 0);
        checkOutput("rst_occupancy", occupancy, 0);
        checkOutput("rst_flit_out",  flit_out,  0);
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_congested", congested, 0);
        checkOutput("rst_inject",    inject_count, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        bit acc, pp, st;
        if (!reset_n) begin
            mq.delete();
            mRun  = 0;
            mCong = 1'b0;
            mInj  = 0;
            mStl  = 0;
            mPeak = 0;
        end else begin
            acc = req_valid && (mq.size() < DEPTH);
            pp  = (mq.size() != 0) && ready_in;
            st  = (mq.size() != 0) && !ready_in;
            if (mq.size() > mPeak) mPeak = mq.size();
            if (pp && mInj != 32'hFFFF_FFFF) mInj++;
            if (st && mStl != 32'hFFFF_FFFF) mStl++;
            mRun = st ? ((mRun < 255) ? mRun + 1 : 255) : 0;
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back({req_dx, req_dy, 32'h0, req_tag});
            if (mq.size() == 0) mRun = 0;
            mCong = (mRun >= STALL_LIMIT);
        end
    end

    always @(negedge clk) begin
        checkOutput("req_ready",  req_ready, (mq.size() < DEPTH));
        checkOutput("valid_out",  valid_out, (mq.size() != 0));
        checkOutput("flit_out",   flit_out,  (mq.size() != 0) ? mq[0] : 64'h0);
        checkOutput("occupancy",  occupancy, mq.size());
        checkOutput("congested",  congested, mCong);
        checkOutput("inject_cnt", inject_count, STATS ? mInj : 0);
        checkOutput("stall_cnt",  stall_count,  STATS ? mStl : 0);
        checkOutput("peak_occ",   peak_occupancy, STATS ? mPeak : 0);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int tg;
        bit wasReady;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_dx    = 8'h0;
        req_dy    = 8'h0;
        req_tag   = 16'h0;
        ready_in  = 1'b0;
        @(posedge clk);
        #1;

        // Single request, router ready
        resetDut();
        applyStimulus(1, 8'd1, 8'd0, 16'h1234, 1);
        checkOutput("t1_flit", flit_out, 64'h0100_0000_0000_1234);
        checkOutput("t1_valid", valid_out, 1);
        applyStimulus(0, 8'd0, 8'd0, 16'h0, 1);
        checkOutput("t1_inject", inject_count, STATS ? 1 : 0);
        checkOutput("t1_stall", stall_count, 0);
        checkOutput("t1_empty", valid_out, 0);

        // Ten back-to-back requests streaming through
        resetDut();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 8'(i), 8'(i + 1), 16'hA000 + 16'(i), 1);
            checkOutput("t2_occ_le1", (occupancy <= 5'd1), 1);
            checkOutput("t2_cong", congested, 0);
        end
        checkOutput("t2_last_flit", flit_out, 64'h090A_0000_0000_A009);
        applyStimulus(0, 8'd0, 8'd0, 16'h0, 1);
        checkOutput("t2_inject", inject_count, STATS ? 10 : 0);

        // Six requests against a blocked router
        resetDut();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_ready) acc++;
            applyStimulus(1, 8'h10, 8'h20, 16'hB000 + 16'(i), 0);
        end
        checkOutput("t3_accepted", acc, 4);
        checkOutput("t3_req_ready", req_ready, 0);
        checkOutput("t3_occ", occupancy, 4);
        checkOutput("t3_head", flit_out, 64'h1020_0000_0000_B000);
        checkOutput("t3_peak", peak_occupancy, STATS ? 4 : 0);

        // Congestion build-up and release
        resetDut();
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 8'h03, 8'h04, 16'hC000 + 16'(i), 0);
        for (int k = 3; k <= 12; k++) begin
            applyStimulus(0, 8'h0, 8'h0, 16'h0, 0);
            if (k == 7) checkOutput("t4_cong_k7", congested, 0);
            if (k == 8) checkOutput("t4_cong_k8", congested, 1);
        end
        checkOutput("t4_stall12", stall_count, STATS ? 12 : 0);
        checkOutput("t4_cong12", congested, 1);
        applyStimulus(0, 8'h0, 8'h0, 16'h0, 1);
        checkOutput("t4_cong_fall", congested, 0);
        checkOutput("t4_occ", occupancy, 2);
        checkOutput("t4_head", flit_out, 64'h0304_0000_0000_C001);
        applyStimulus(0, 8'h0, 8'h0, 16'h0, 1);
        applyStimulus(0, 8'h0, 8'h0, 16'h0, 1);
        checkOutput("t4_drained", valid_out, 0);

        // Full FIFO with ready router, then wrap-around traffic
        resetDut();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 8'h0D, 8'h0E, 16'hD000 + 16'(i), 0);
        checkOutput("t5_full_ready", req_ready, 0);
        tg = 4;
        for (int i = 0; i < 14; i++) begin
            wasReady = req_ready;
            applyStimulus(1, 8'h0D, 8'h0E, 16'hD000 + 16'(tg), (i % 3) != 2);
            if (wasReady) tg++;
            if (i == 0) checkOutput("t5_ready_back", req_ready, 1);
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 8'h0, 8'h0, 16'h0, 1);
        checkOutput("t5_drained", valid_out, 0);

        // Reset with three flits queued
        resetDut();
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 8'h07, 8'h08, 16'hF000 + 16'(i), 0);
        checkOutput("t6_occ_before", occupancy, 3);
        resetDut();
        applyStimulus(1, 8'h05, 8'h06, 16'hEEEE, 1);
        checkOutput("t6_new_flit", flit_out, 64'h0506_0000_0000_EEEE);
        applyStimulus(0, 8'h0, 8'h0, 16'h0, 1);
        checkOutput("t6_empty", valid_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/noc_local_injector.md
# noc_local_injector

Network-interface injection stage in front of the router's local input port. Accepts destination/tag requests from the tile, packs them into 64-bit flits, buffers them in a small FIFO, and presents them to the router's local input with a valid/ready handshake. It also tracks back-pressure from the router with a congestion state machine and optional statistics counters, complementing the router's own stall and congestion counters.

## Interface
- FLIT_WIDTH, 64, flit width; must be 64.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- STALL_LIMIT, 8, consecutive stalled cycles before `congested` asserts; 1..255.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  tile request valid.
- req_ready  out  1  request accepted when `req_valid && req_ready`.
- req_dx  in  8  destination X offset.
- req_dy  in  8  destination Y offset.
- req_tag  in  16  payload tag.
- flit_out  out  64  to router `flit_in_local`.
- valid_out  out  1  to router `valid_in_local`.
- ready_in  in  1  from router `ready_out_local`.
- occupancy  out  5  FIFO entries in use.
- congested  out  1  high in the CONGESTED state.
- inject_count  out  32  flits transferred to the router.
- stall_count  out  32  cycles with `valid_out && !ready_in`.
- peak_occupancy  out  5  maximum `occupancy` since reset.

## Operation
- Flit packing: [63:56]=dx, [55:48]=dy, [47:46]=2'b00, [45:16]=0, [15:0]=tag.
- Push: `req_valid && req_ready`. `req_ready = (occupancy < DEPTH)`, registered-count based and independent of `ready_in` (no full-bypass).
- Pop: `valid_out && ready_in`. `valid_out = (occupancy != 0)`. `flit_out` is the FIFO head and holds stable while stalled.
- Push and pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- Ordering is strict FIFO. There is no drop, reorder, or retry.
- Congestion FSM:
  - IDLE (empty) → FLOWING on non-empty.
  - FLOWING → STALLED on a cycle with `valid_out && !ready_in`; `stall_run` = 1.
  - STALLED: `stall_run` increments each stalled cycle. At `stall_run == STALL_LIMIT` → CONGESTED.
  - STALLED/CONGESTED → FLOWING on any pop, clearing `stall_run`. If that pop empties the FIFO → IDLE.
  - Any state → IDLE when empty.
  - `stall_run` is 8 bits and saturates.
- Counters saturate at 32'hFFFF_FFFF. `peak_occupancy` updates to the registered occupancy whenever it is larger.

## Timing
- Reset values:
  - `req_ready` = 1.
  - `valid_out` = 0, `flit_out` = 0, `occupancy` = 0, `congested` = 0.
  - All counters = 0, `peak_occupancy` = 0.
  - FSM in IDLE.
- Latency: a request accepted at edge N appears on `valid_out`/`flit_out` after edge N (visible during cycle N+1). Minimum tile-to-router latency is 1 cycle.
- Throughput is 1 flit/cycle while `ready_in` stays high.
- `congested` is registered. It rises in the cycle after the STALL_LIMIT-th consecutive stalled cycle and falls in the cycle after the releasing pop.
- Asserting `reset_n` mid-operation discards FIFO contents immediately (asynchronous). `valid_out` drops without a handshake. The first accept after deassertion is at the first rising edge with `reset_n` high.

## Configuration
- `NOC_INJECTOR_STATS_EN` defined: `inject_count`, `stall_count` and `peak_occupancy` are implemented as specified.
- Not defined: those three outputs are tied to 0 and their registers are removed. The FIFO, FSM and `congested` behave identically.

## Structure
- Shared package `noc_pkg`:
  - flit field offsets (DX_MSB/LSB, DY_MSB/LSB, TAG_MSB/LSB);
  - the `make_flit(dx,dy,tag)` function;
  - the FSM state enum `ni_state_t` (IDLE, FLOWING, STALLED, CONGESTED);
  - the counter saturation constant.
- One sub-module, `noc_ni_fifo`: parameterised synchronous FIFO with count output and asynchronous active-low reset. The top level holds packing, the FSM and the counters.

## Test plan
- Single request dx=1, dy=0, tag=16'h1234 with `ready_in`=1 → `flit_out` = 64'h0100_0000_0000_1234 one cycle later, `inject_count`=1, `stall_count`=0.
- 10 back-to-back requests with `ready_in`=1 → 10 flits in order, one per cycle, `occupancy` ≤ 1, `congested` never high.
- `ready_in`=0, 6 requests issued → exactly 4 accepted, `req_ready`=0 at `occupancy`=4, `peak_occupancy`=4, `flit_out` stable.
- Hold `ready_in`=0 for 12 cycles with a non-empty FIFO → `congested` rises after the 8th stalled cycle, `stall_count`=12. Release `ready_in` → `congested` falls a cycle later and the FIFO drains in order.
- Full FIFO with `ready_in`=1 and `req_valid`=1 → `req_ready` stays 0 that cycle and returns to 1 the next; no flit lost. Wrap-around is verified across 3×DEPTH flits.
- Assert `reset_n` low with 3 queued flits → outputs return to reset values immediately; after release, a new tag is the first flit out.
